// File: rtl/i2c_target.sv
// I2C target (responder) with a 16-bit word port toward the core.
// SCL/SDA are oversampled by clk. SDA is open-drain: sda_oe=1 pulls it low.
// No clock stretching is performed.
module i2c_target #(
    parameter logic [6:0]  ADDR        = 7'h42,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    output logic [15:0] rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    input  logic [15:0] tx_data,
    output logic        tx_taken,
    output logic        busy
);

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StWrByte,
        StWrAck,
        StRdByte,
        StRdAck,
        StIgnore
    } state_e;

    // Synchroniser chains; reset to the idle-bus level so reset release
    // never looks like a bus edge.
    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_dly_q;
    logic                   sda_dly_q;

    logic scl_s;
    logic sda_s;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    // FSM and datapath registers
    state_e      state_q;
    logic [3:0]  bit_cnt_q;
    logic [6:0]  shift_q;
    logic [7:0]  hold_q;
    logic [15:0] tx_shift_q;
    logic        rw_q;
    logic        byte_idx_q;
    logic        ack_hold_q;
    logic        ack_en_q;
    logic        nack_q;
    logic        sda_oe_q;
    logic [15:0] rx_data_q;
    logic        rx_valid_q;
    logic        tx_taken_q;
    logic        busy_q;

    logic [7:0]  byte_in;

    // Synchronise the bus pins and keep one delayed copy for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_dly_q  <= 1'b1;
            sda_dly_q  <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
            scl_dly_q  <= scl_sync_q[SYNC_STAGES-1];
            sda_dly_q  <= sda_sync_q[SYNC_STAGES-1];
        end
    end

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_dly_q;
    assign scl_fall  = ~scl_s & scl_dly_q;
    // SDA edges are only bus conditions while SCL is stably high.
    assign start_det = scl_s & scl_dly_q & sda_dly_q & ~sda_s;
    assign stop_det  = scl_s & scl_dly_q & ~sda_dly_q & sda_s;

    // Byte as it stands once the current SCL rise is folded in.
    assign byte_in = {shift_q, sda_s};

    // Protocol FSM; all outputs are registered here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            bit_cnt_q  <= 4'd0;
            shift_q    <= 7'd0;
            hold_q     <= 8'd0;
            tx_shift_q <= 16'd0;
            rw_q       <= 1'b0;
            byte_idx_q <= 1'b0;
            ack_hold_q <= 1'b0;
            ack_en_q   <= 1'b0;
            nack_q     <= 1'b0;
            sda_oe_q   <= 1'b0;
            rx_data_q  <= 16'd0;
            rx_valid_q <= 1'b0;
            tx_taken_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            tx_taken_q <= 1'b0;
            if (stop_det) begin
                state_q    <= StIdle;
                sda_oe_q   <= 1'b0;
                busy_q     <= 1'b0;
                bit_cnt_q  <= 4'd0;
                byte_idx_q <= 1'b0;
                ack_hold_q <= 1'b0;
            end else if (start_det) begin
                // Also covers repeated START; any partial word is dropped.
                state_q    <= StAddr;
                sda_oe_q   <= 1'b0;
                bit_cnt_q  <= 4'd0;
                byte_idx_q <= 1'b0;
                ack_hold_q <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        sda_oe_q <= 1'b0;
                    end

                    StAddr: begin
                        if (scl_rise) begin
                            shift_q   <= byte_in[6:0];
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                            if (bit_cnt_q == 4'd7) begin
                                ack_hold_q <= 1'b0;
                                if (byte_in[7:1] == ADDR) begin
                                    state_q <= StAddrAck;
                                    busy_q  <= 1'b1;
                                    rw_q    <= byte_in[0];
                                end else begin
                                    state_q <= StIgnore;
                                    busy_q  <= 1'b0;
                                end
                            end
                        end
                    end

                    StAddrAck: begin
                        if (scl_fall) begin
                            if (!ack_hold_q) begin
                                // Fall after bit 8: start the ACK.
                                sda_oe_q   <= 1'b1;
                                ack_hold_q <= 1'b1;
                            end else begin
                                // Fall ending the 9th clock.
                                ack_hold_q <= 1'b0;
                                bit_cnt_q  <= 4'd0;
                                byte_idx_q <= 1'b0;
                                if (rw_q) begin
                                    tx_shift_q <= {tx_data[14:0], 1'b0};
                                    sda_oe_q   <= ~tx_data[15];
                                    tx_taken_q <= 1'b1;
                                    state_q    <= StRdByte;
                                end else begin
                                    sda_oe_q <= 1'b0;
                                    state_q  <= StWrByte;
                                end
                            end
                        end
                    end

                    StWrByte: begin
                        if (scl_rise) begin
                            shift_q   <= byte_in[6:0];
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                            if (bit_cnt_q == 4'd7) begin
                                byte_idx_q <= ~byte_idx_q;
                                ack_hold_q <= 1'b0;
                                state_q    <= StWrAck;
                                if (!byte_idx_q) begin
                                    hold_q   <= byte_in;
                                    ack_en_q <= 1'b1;
                                end else if (rx_ready) begin
                                    rx_data_q  <= {hold_q, byte_in};
                                    rx_valid_q <= 1'b1;
                                    ack_en_q   <= 1'b1;
                                end else begin
                                    // Core cannot take the word: NACK it.
                                    ack_en_q <= 1'b0;
                                end
                            end
                        end
                    end

                    StWrAck: begin
                        if (scl_fall) begin
                            if (!ack_hold_q) begin
                                sda_oe_q   <= ack_en_q;
                                ack_hold_q <= 1'b1;
                            end else begin
                                sda_oe_q   <= 1'b0;
                                ack_hold_q <= 1'b0;
                                bit_cnt_q  <= 4'd0;
                                state_q    <= StWrByte;
                            end
                        end
                    end

                    StRdByte: begin
                        if (scl_rise) begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt_q == 4'd8) begin
                                // Hand SDA to the controller for its ACK.
                                sda_oe_q   <= 1'b0;
                                bit_cnt_q  <= 4'd0;
                                ack_hold_q <= 1'b0;
                                state_q    <= StRdAck;
                            end else begin
                                sda_oe_q   <= ~tx_shift_q[15];
                                tx_shift_q <= {tx_shift_q[14:0], 1'b0};
                            end
                        end
                    end

                    StRdAck: begin
                        if (scl_rise) begin
                            nack_q     <= sda_s;
                            ack_hold_q <= 1'b1;
                        end else if (scl_fall && ack_hold_q) begin
                            ack_hold_q <= 1'b0;
                            if (nack_q) begin
                                sda_oe_q <= 1'b0;
                                state_q  <= StIgnore;
                            end else if (!byte_idx_q) begin
                                // Low byte is already sitting in the top of the shifter.
                                byte_idx_q <= 1'b1;
                                sda_oe_q   <= ~tx_shift_q[15];
                                tx_shift_q <= {tx_shift_q[14:0], 1'b0};
                                state_q    <= StRdByte;
                            end else begin
                                byte_idx_q <= 1'b0;
                                tx_shift_q <= {tx_data[14:0], 1'b0};
                                sda_oe_q   <= ~tx_data[15];
                                tx_taken_q <= 1'b1;
                                state_q    <= StRdByte;
                            end
                        end
                    end

                    StIgnore: begin
                        sda_oe_q <= 1'b0;
                    end

                    default: begin
                        state_q  <= StIdle;
                        sda_oe_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sda_oe   = sda_oe_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign tx_taken = tx_taken_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: bit-banged I2C controller on a wired-AND SDA.
module tb_i2c_target;

    logic        clk;
    logic        reset;
    logic        scl;
    logic        sda_m;
    logic        sda_bus;
    logic        sda_oe;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [15:0] tx_data;
    logic        tx_taken;
    logic        busy;

    int total;
    int bad;
    int rxv_cnt;
    int txt_cnt;
    int oe_cnt;

    assign sda_bus = sda_m & ~sda_oe;

    i2c_target #(
        .ADDR        (7'h42),
        .SYNC_STAGES (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .scl_in   (scl),
        .sda_in   (sda_bus),
        .sda_oe   (sda_oe),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .tx_data  (tx_data),
        .tx_taken (tx_taken),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse / drive monitors
    always @(posedge clk) begin
        if (rx_valid) rxv_cnt <= rxv_cnt + 1;
        if (tx_taken) txt_cnt <= txt_cnt + 1;
        if (sda_oe)   oe_cnt  <= oe_cnt + 1;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SCL period: 8 clk low, 8 clk high; bus sampled mid-high.
    task automatic bit_xfer(input logic b, output logic s);
        scl = 1'b0;
        wclk(4);
        sda_m = b;
        wclk(4);
        scl = 1'b1;
        wclk(4);
        s = sda_bus;
        wclk(4);
    endtask

    task automatic bus_start();
        wclk(4);
        sda_m = 1'b0;
        wclk(4);
    endtask

    task automatic bus_rstart();
        scl = 1'b0;
        wclk(4);
        sda_m = 1'b1;
        wclk(4);
        scl = 1'b1;
        wclk(4);
        sda_m = 1'b0;
        wclk(4);
    endtask

    task automatic bus_stop();
        scl = 1'b0;
        wclk(4);
        sda_m = 1'b0;
        wclk(4);
        scl = 1'b1;
        wclk(4);
        sda_m = 1'b1;
        wclk(8);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_xfer(d[i], s);
        bit_xfer(1'b1, ack);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, s);
            d[i] = s;
        end
        bit_xfer(mack, s);
    endtask

    initial begin
        logic       ack;
        logic [7:0] rd;
        logic       s;
        int         rxv0;
        int         txt0;
        int         oe0;
        logic [7:0] addr_rd;

        total    = 0;
        bad      = 0;
        rxv_cnt  = 0;
        txt_cnt  = 0;
        oe_cnt   = 0;
        reset    = 1'b0;
        scl      = 1'b1;
        sda_m    = 1'b1;
        rx_ready = 1'b1;
        tx_data  = 16'h0000;
        wclk(3);

        // Reset state
        check("rst_sda_oe", {15'd0, sda_oe}, 16'd0);
        check("rst_busy", {15'd0, busy}, 16'd0);
        check("rst_rx_valid", {15'd0, rx_valid}, 16'd0);
        check("rst_tx_taken", {15'd0, tx_taken}, 16'd0);
        check("rst_rx_data", rx_data, 16'h0000);
        reset = 1'b1;
        wclk(10);

        // Write A53C
        rxv0 = rxv_cnt;
        bus_start();
        write_byte(8'h84, ack);
        check("wr_addr_ack", {15'd0, ack}, 16'd0);
        check("wr_busy", {15'd0, busy}, 16'd1);
        write_byte(8'hA5, ack);
        check("wr_b0_ack", {15'd0, ack}, 16'd0);
        write_byte(8'h3C, ack);
        check("wr_b1_ack", {15'd0, ack}, 16'd0);
        bus_stop();
        check("wr_rxv_count", 16'(rxv_cnt - rxv0), 16'd1);
        check("wr_rx_data", rx_data, 16'hA53C);
        check("wr_busy_after_stop", {15'd0, busy}, 16'd0);

        // Wrong address
        rxv0 = rxv_cnt;
        oe0  = oe_cnt;
        bus_start();
        write_byte(8'h50, ack);
        check("wa_addr_nack", {15'd0, ack}, 16'd1);
        write_byte(8'hFF, ack);
        check("wa_data_nack", {15'd0, ack}, 16'd1);
        check("wa_busy", {15'd0, busy}, 16'd0);
        bus_stop();
        check("wa_oe_count", 16'(oe_cnt - oe0), 16'd0);
        check("wa_rxv_count", 16'(rxv_cnt - rxv0), 16'd0);

        // Read BEEF, ACK then NACK
        tx_data = 16'hBEEF;
        txt0    = txt_cnt;
        bus_start();
        write_byte(8'h85, ack);
        check("rd_addr_ack", {15'd0, ack}, 16'd0);
        read_byte(1'b0, rd);
        check("rd_byte_hi", {8'd0, rd}, 16'h00BE);
        read_byte(1'b1, rd);
        check("rd_byte_lo", {8'd0, rd}, 16'h00EF);
        check("rd_oe_released", {15'd0, sda_oe}, 16'd0);
        check("rd_tx_taken_count", 16'(txt_cnt - txt0), 16'd1);
        bus_stop();
        check("rd_busy_after_stop", {15'd0, busy}, 16'd0);

        // Partial word then STOP
        rxv0 = rxv_cnt;
        bus_start();
        write_byte(8'h84, ack);
        check("pw_addr_ack", {15'd0, ack}, 16'd0);
        write_byte(8'h11, ack);
        check("pw_b0_ack", {15'd0, ack}, 16'd0);
        bus_stop();
        check("pw_rxv_count", 16'(rxv_cnt - rxv0), 16'd0);
        check("pw_rx_data", rx_data, 16'hA53C);

        // Backpressure: second byte NACKed
        rx_ready = 1'b0;
        rxv0     = rxv_cnt;
        bus_start();
        write_byte(8'h84, ack);
        check("bp_addr_ack", {15'd0, ack}, 16'd0);
        write_byte(8'h22, ack);
        check("bp_b0_ack", {15'd0, ack}, 16'd0);
        write_byte(8'h33, ack);
        check("bp_b1_nack", {15'd0, ack}, 16'd1);
        check("bp_rxv_count", 16'(rxv_cnt - rxv0), 16'd0);
        check("bp_rx_data", rx_data, 16'hA53C);
        bus_stop();
        rx_ready = 1'b1;

        // Repeated START into a read
        rxv0    = rxv_cnt;
        txt0    = txt_cnt;
        tx_data = 16'h0001;
        bus_start();
        write_byte(8'h84, ack);
        check("sr_wr_addr_ack", {15'd0, ack}, 16'd0);
        write_byte(8'h12, ack);
        check("sr_wr_b0_ack", {15'd0, ack}, 16'd0);
        bus_rstart();
        write_byte(8'h85, ack);
        check("sr_rd_addr_ack", {15'd0, ack}, 16'd0);
        read_byte(1'b0, rd);
        check("sr_rd_hi", {8'd0, rd}, 16'h0000);
        read_byte(1'b1, rd);
        check("sr_rd_lo", {8'd0, rd}, 16'h0001);
        bus_stop();
        check("sr_rxv_count", 16'(rxv_cnt - rxv0), 16'd0);
        check("sr_tx_taken_count", 16'(txt_cnt - txt0), 16'd1);
        check("sr_rx_data", rx_data, 16'hA53C);

        // Async reset while target drives the address ACK
        addr_rd = 8'h85;
        bus_start();
        for (int i = 7; i >= 0; i--) bit_xfer(addr_rd[i], s);
        scl = 1'b0;
        wclk(8);
        scl = 1'b1;
        wclk(4);
        check("ar_oe_before", {15'd0, sda_oe}, 16'd1);
        check("ar_busy_before", {15'd0, busy}, 16'd1);
        reset = 1'b0;
        #1;
        check("ar_oe_async", {15'd0, sda_oe}, 16'd0);
        check("ar_busy_async", {15'd0, busy}, 16'd0);
        wclk(4);
        reset = 1'b1;
        wclk(8);
        bus_start();
        write_byte(8'h84, ack);
        check("ar_addr_ack", {15'd0, ack}, 16'd0);
        bus_stop();
        check("ar_busy_end", {15'd0, busy}, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- Responder (target/slave) end of the on-chip I2C link. It answers the datapath's I2C controller and gives the core a bus-addressable 16-bit data port.
- Oversamples SCL/SDA with the system clock. Detects START/STOP, matches a 7-bit address, and handles both directions:
  - Write: assembles 16-bit words from two received bytes.
  - Read: serialises a 16-bit word as two bytes.
- SDA is open-drain (low-drive enable only). SCL is input-only; no clock stretching.

Parameters:
- ADDR, 7'h42, 7-bit target address compared against the first byte after START.
- SYNC_STAGES, 2, synchroniser depth on scl_in/sda_in (≥2).

Ports:
- clk  in  1  system clock; must be ≥8× SCL frequency.
- reset  in  1  asynchronous, active-low reset.
- scl_in  in  1  bus SCL level.
- sda_in  in  1  bus SDA level.
- sda_oe  out  1  1 = pull SDA low, 0 = release.
- rx_data  out  16  last complete received word; first byte lands in [15:8].
- rx_valid  out  1  one-clk pulse when rx_data updates.
- rx_ready  in  1  core can accept a word; sampled when a word's second byte completes.
- tx_data  in  16  word returned on read; [15:8] sent first.
- tx_taken  out  1  one-clk pulse when tx_data is latched into the shifter.
- busy  out  1  high from address match to STOP or non-matching START.

Behaviour:
- Reset (reset=0, async): state IDLE, sda_oe=0, rx_data=0, rx_valid=0, tx_taken=0, busy=0, bit/byte counters cleared.
- Synchronisation:
  - scl_in/sda_in pass through SYNC_STAGES flops, plus one delay flop for edge detection.
  - Pin-to-event latency: SYNC_STAGES+1 clk.
- Bus events, decoded from the synced signals:
  - START: sda falls while scl high.
  - STOP: sda rises while scl high.
  - Data is sampled on SCL rise. sda_oe changes only on SCL fall.
- START in any state (repeated START included): release SDA, clear bit count, go to ADDR. A partial word is discarded.
- STOP in any state: release SDA, go to IDLE, busy=0. A partial word is discarded and rx_valid is not pulsed.
- States:
  - IDLE: wait for START.
  - ADDR: shift in 8 bits MSB-first. After the 8th rise:
    - byte[7:1]==ADDR → ADDR_ACK, busy=1, byte[0] latched as R/W.
    - otherwise → IGNORE.
  - ADDR_ACK: on the SCL fall after bit 8, sda_oe=1; hold through the 9th clock; release on the 9th fall.
    - R/W=0 → WR_BYTE.
    - R/W=1 → latch tx_data, pulse tx_taken, go to RD_BYTE with byte index 0.
  - WR_BYTE: shift 8 bits.
    - Byte index 0 → store into a hold register [15:8], then WR_ACK with ACK.
    - Byte index 1 → if rx_ready=1: rx_data={hold,byte}, rx_valid pulses on that clk, then ACK. If rx_ready=0: NACK (leave SDA released), rx_data unchanged, no pulse.
    - Byte index toggles 0/1 after each byte. A third byte starts a new word.
  - WR_ACK: drive/release for the 9th clock as above; return to WR_BYTE.
  - RD_BYTE:
    - Drive the current bit on each SCL fall: bit 0 → sda_oe=1, bit 1 → sda_oe=0.
    - The first bit is driven on the fall ending the address ACK.
    - After 8 bits, release SDA and go to RD_ACK.
  - RD_ACK: sample SDA on the 9th rise.
    - Master ACK (0), byte index 0 → send the low byte.
    - Master ACK (0), byte index 1 → relatch tx_data, pulse tx_taken, send a new high byte.
    - Master NACK (1) → release SDA and go to IGNORE.
  - IGNORE: SDA released; wait for START/STOP.
- Counters: bit counter 0–8 wraps at each ACK slot; byte index is 1 bit.
- Simultaneous events: STOP/START take priority over SCL-edge processing in the same clk.
- Outputs rx_valid and tx_taken are single-cycle and never asserted together.

Test Plan:
- Reset low mid-read with sda_oe=1 → sda_oe=0 immediately (async), busy=0, state IDLE. Next START+0x84 is ACKed normally.
- Write: START, 0x84, 0xA5, 0x3C, STOP with rx_ready=1 → three ACKs (SDA low on the 9th clocks); exactly one rx_valid; rx_data=16'hA53C; busy falls after STOP.
- Wrong address: START, 0x50, 0xFF, STOP → sda_oe never asserted, busy=0, no rx_valid.
- Read: tx_data=16'hBEEF, START, 0x85, master ACKs byte 1 and NACKs byte 2, then STOP → bytes 0xBE then 0xEF on SDA; one tx_taken; SDA released after the NACK.
- Partial + backpressure:
  - START, 0x84, 0x11, STOP → no rx_valid; rx_data keeps its previous value.
  - START, 0x84, 0x22, 0x33 with rx_ready=0 → second byte NACKed; no rx_valid.
- Repeated START: write 0x84, 0x12, then Sr, 0x85 with tx_data=16'h0001 → 0x12 discarded, read returns 0x00 then 0x01.
